mdu_ctrl: RTL and testbench

//  Sequencer for multi-cycle multiply/divide ops that the single-cycle EXE ALU cannot finish in one cycle.

---
 rtl/mdu_ctrl_pkg.sv | 22 ++
 rtl/mdu_div_step.sv | 18 +
 rtl/mdu_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: opcodes, FSM states and bad-op result shared by the multiply/divide sequencer.
// MDU_DIV_EN selects whether DIV/REM count as valid operations.
package mdu_ctrl_pkg;
    localparam logic [7:0]  ALU_OPCODE_MUL   = 8'h20;
    localparam logic [7:0]  ALU_OPCODE_DIV   = 8'h21;
    localparam logic [7:0]  ALU_OPCODE_REM   = 8'h22;
    localparam logic [15:0] MDU_BADOP_RESULT = 16'h00fe;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_DONE = 2'd2
    } mdu_st_e;

    function automatic logic op_valid(input logic [7:0] op);
`ifdef MDU_DIV_EN
        return op == ALU_OPCODE_MUL || op == ALU_OPCODE_DIV || op == ALU_OPCODE_REM;
`else
        return op == ALU_OPCODE_MUL;
`endif
    endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step; exists only when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] shifted, diff;
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, div_i};
    assign q_o     = ~diff[WIDTH+1];
    assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule
`endif

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer that stalls the pipeline for WIDTH iterations.
// DIV/REM are available only when MDU_DIV_EN is defined; otherwise they return the bad-op result.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdui_start,
    input  logic [7:0]       mdui_alu_opcode,
    input  logic [WIDTH-1:0] mdui_op1,
    input  logic [WIDTH-1:0] mdui_op2,
    input  logic [3:0]       mdui_wreg_addr,
    input  logic             mdui_flush,
    output logic             mduo_stall,
    output logic             mduo_done,
    output logic [WIDTH-1:0] mduo_result,
    output logic [3:0]       mduo_wreg_addr
);
    mdu_st_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       op_q;
    logic [3:0]       wreg_q;
    logic             go, accept, bad, last;

    assign go     = state_q == MDU_ST_IDLE && mdui_start && !mdui_flush;
    assign accept = go && op_valid(mdui_alu_opcode);
    assign bad    = go && !op_valid(mdui_alu_opcode);
    assign last   = state_q == MDU_ST_CALC && cnt_q == CNT_W'(1);

`ifdef MDU_DIV_EN
    logic [WIDTH:0] div_rem;
    logic           div_q;
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q),
        .bit_i (a_q[WIDTH-1]),
        .div_i (b_q),
        .rem_o (div_rem),
        .q_o   (div_q)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MDU_ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = mdui_flush                ? MDU_ST_IDLE :
                  state_q == MDU_ST_IDLE    ? (accept ? MDU_ST_CALC : (bad ? MDU_ST_DONE : MDU_ST_IDLE)) :
                  state_q == MDU_ST_CALC    ? (last ? MDU_ST_DONE : MDU_ST_CALC) : MDU_ST_IDLE;
    end

    always_comb begin
        mduo_stall     = accept || (state_q == MDU_ST_CALC && !mdui_flush);
        mduo_done      = state_q == MDU_ST_DONE && !mdui_flush;
        mduo_result    = res_q;
        mduo_wreg_addr = wreg_q;
    end

    // a_q holds multiplicand (shifting left) or dividend that becomes the quotient
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (accept) begin
            a_d   = mdui_op1;
            b_d   = mdui_op2;
            acc_d = '0;
            cnt_d = CNT_W'(WIDTH);
        end else if (state_q == MDU_ST_CALC) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == ALU_OPCODE_MUL) begin
                acc_d = acc_q + (WIDTH+1)'(b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end
`ifdef MDU_DIV_EN
            else begin
                acc_d = div_rem;
                a_d   = {a_q[WIDTH-2:0], div_q};
            end
`endif
            if (last) res_d = op_q == ALU_OPCODE_DIV ? a_d : acc_d[WIDTH-1:0];
        end else if (bad) begin
            res_d = WIDTH'(MDU_BADOP_RESULT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            op_q   <= '0;
            wreg_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            if (accept) op_q <= mdui_alu_opcode;
            if (go) wreg_q <= mdui_wreg_addr;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
    logic [7:0]  opc = '0;
    logic [15:0] op1 = '0, op2 = '0;
    logic [3:0]  wa = '0;
    logic        stall, done;
    logic [15:0] res;
    logic [3:0]  wo;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .mdui_start      (start),
        .mdui_alu_opcode (opc),
        .mdui_op1        (op1),
        .mdui_op2        (op2),
        .mdui_wreg_addr  (wa),
        .mdui_flush      (flush),
        .mduo_stall      (stall),
        .mduo_done       (done),
        .mduo_result     (res),
        .mduo_wreg_addr  (wo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output bit v, output logic [15:0] r);
        v = 1'b1;
        if (op == ALU_OPCODE_MUL) r = a * b;
        else if (DIV_EN && op == ALU_OPCODE_DIV) r = (b == 0) ? 16'hffff : a / b;
        else if (DIV_EN && op == ALU_OPCODE_REM) r = (b == 0) ? a : a % b;
        else begin
            v = 1'b0;
            r = 16'h00fe;
        end
    endfunction

    task automatic quiet(input string tag);
        int dc = 0, sc = 0;
        repeat (20) begin
            @(negedge clk);
            dc += int'(done);
            sc += int'(stall);
        end
        chk({tag, "_done"}, dc, 0);
        chk({tag, "_stall"}, sc, 0);
    endtask

    // poke: 1 = extra start mid-CALC, 2 = start during the DONE cycle
    task automatic do_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] w, input int poke);
        bit          v;
        logic [15:0] er;
        int          lat = 0, st = 0;
        model(op, a, b, v, er);
        @(negedge clk);
        start = 1'b1; opc = op; op1 = a; op2 = b; wa = w;
        #1;
        chk("stall_at_start", stall, v);
        while (done !== 1'b1 && lat < 40) begin
            if (stall === 1'b1) st++;
            @(negedge clk);
            start = (poke == 1 && lat == 4);
            if (start) begin
                opc = ALU_OPCODE_MUL; op1 = 16'($urandom); op2 = 16'($urandom); wa = ~w;
            end
            lat++;
        end
        chk("latency", lat, v ? 17 : 1);
        chk("result", res, er);
        chk("wreg", wo, w);
        chk("stall_cycles", st, v ? 17 : 0);
        chk("stall_in_done", stall, 0);
        if (poke == 2) begin
            start = 1'b1; opc = ALU_OPCODE_MUL; op1 = 16'd9; op2 = 16'd9;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_width", done, 0);
        if (poke == 2) quiet("start_in_done");
    endtask

    initial begin
        logic [7:0] rop;
        logic [15:0] ra, rb;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_result", res, 0);
        chk("rst_wreg", wo, 0);
        #11 rst = 1'b1;

        do_op(ALU_OPCODE_MUL, 16'h0003, 16'h0007, 4'h2, 0);
        do_op(ALU_OPCODE_MUL, 16'hffff, 16'h0002, 4'h5, 0);
        do_op(ALU_OPCODE_DIV, 16'd100, 16'd7, 4'h3, 0);
        do_op(ALU_OPCODE_REM, 16'd100, 16'd7, 4'h4, 0);
        do_op(ALU_OPCODE_DIV, 16'h1234, 16'h0000, 4'h6, 0);
        do_op(ALU_OPCODE_REM, 16'h1234, 16'h0000, 4'h7, 0);

        // flush mid-CALC
        @(negedge clk);
        start = 1'b1; opc = ALU_OPCODE_MUL; op1 = 16'd5; op2 = 16'd5; wa = 4'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall_comb", stall, 0);
        chk("flush_done", done, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_stall_after", stall, 0);
        quiet("after_flush");
        do_op(ALU_OPCODE_MUL, 16'h0002, 16'h0002, 4'h1, 0);

        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; opc = ALU_OPCODE_MUL; op1 = 16'd3; op2 = 16'd3;
        #1;
        chk("flush_start_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        quiet("flush_start");

        // async reset mid-CALC
        @(negedge clk);
        start = 1'b1; opc = ALU_OPCODE_MUL; op1 = 16'd11; op2 = 16'd13; wa = 4'hc;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_done", done, 0);
        chk("arst_result", res, 0);
        chk("arst_wreg", wo, 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(ALU_OPCODE_MUL, 16'd11, 16'd13, 4'hc, 0);
        quiet("after_reset");

        do_op(8'hff, 16'h1111, 16'h2222, 4'ha, 0);
        do_op(ALU_OPCODE_MUL, 16'h0123, 16'h0456, 4'hb, 1);
        do_op(ALU_OPCODE_DIV, 16'hbeef, 16'h0013, 4'hd, 1);
        do_op(ALU_OPCODE_MUL, 16'h0007, 16'h0009, 4'he, 2);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       rop = ALU_OPCODE_MUL;
                1:       rop = ALU_OPCODE_DIV;
                2:       rop = ALU_OPCODE_REM;
                default: rop = 8'($urandom);
            endcase
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 16));
            do_op(rop, ra, rb, 4'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
